// File: rtl/mic_array_capture_if.sv
// Word stream from the capture block toward the HPS-side DMA/bridge.
// The master drives the sample word and framing flags; the slave returns out_ready.
interface mic_array_capture_if #(
  parameter int W  = 16,
  parameter int CW = 3
) ();
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;

  modport master (
    output out_data, out_chan, out_valid, out_sop, out_eop,
    input  out_ready
  );

  modport slave (
    input  out_data, out_chan, out_valid, out_sop, out_eop,
    output out_ready
  );
endinterface

// File: rtl/mic_array_capture.sv
// Multi-channel microphone frame capture: strobe-synchronised snapshot into a frame FIFO,
// then serialised channel by channel onto a valid/ready word stream.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | gate closed; waiting for enable, picks mode from oneshot
// S_CONT    | gate open; continuous capture
// S_ARMED   | gate closed; one-shot mode waiting for trigger
// S_CAPTURE | gate open; one-shot block in progress (busy)
// S_DONE    | gate closed; block complete, trigger ignored until enable drops
module mic_array_capture #(
  parameter int NCH       = 6,
  parameter int W         = 16,
  parameter int DEPTH     = 256,
  parameter int BLOCK_LEN = 1024,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int FW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 sample_strobe_in,
  input  logic [NCH*W-1:0]     ch_data,
  input  logic                 enable,
  input  logic                 oneshot,
  input  logic                 trigger,
  mic_array_capture_if.master  out_if,
  output logic [FW-1:0]        fill_level,
  output logic [15:0]          overflow_count,
  output logic                 busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BLOCK_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONT,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       strobe_sync;
  logic             tick;
  logic             gate_open;
  logic [BW-1:0]    blk_cnt;
  logic             blk_last;

  logic [NCH*W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [FW-1:0]    fill_q;
  logic             fifo_full, fifo_empty;
  logic             wr_req, wr_en, drop, pop;

  logic [NCH*W-1:0] frame_q;
  logic [CW-1:0]    chan_q;
  logic             valid_q;
  logic             chan_last;
  logic             ser_free;

  // Two flops bring the strobe into clk_clk; the third gives the rising-edge compare.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) strobe_sync <= '0;
    else             strobe_sync <= {strobe_sync[1:0], sample_strobe_in};
  end

  assign tick      = strobe_sync[1] & ~strobe_sync[2];
  assign gate_open = (state_q == S_CONT) || (state_q == S_CAPTURE);
  assign blk_last  = (blk_cnt == BW'(BLOCK_LEN - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = oneshot ? S_ARMED : S_CONT;
      end
      S_CONT: begin
        if (!enable || oneshot) state_d = S_IDLE;
      end
      S_ARMED: begin
        if (!enable)      state_d = S_IDLE;
        else if (trigger) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!enable)               state_d = S_IDLE;
        else if (tick && blk_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dropped frames still advance the block count, so it follows ticks, not writes.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      blk_cnt <= '0;
    else if (state_q == S_ARMED && state_d == S_CAPTURE)
      blk_cnt <= '0;
    else if (state_q == S_CAPTURE && tick)
      blk_cnt <= blk_cnt + BW'(1);
  end

  assign busy = (state_q == S_CAPTURE);

  assign fifo_full  = (fill_q == FW'(DEPTH));
  assign fifo_empty = (fill_q == '0);
  assign chan_last  = (chan_q == CW'(NCH - 1));
  assign ser_free   = !valid_q || (out_if.out_ready && chan_last);
  assign pop        = ser_free && !fifo_empty;
  assign wr_req     = tick && gate_open;
  assign wr_en      = wr_req && (!fifo_full || pop);
  assign drop       = wr_req && fifo_full && !pop;

  always_ff @(posedge clk_clk) begin
    if (wr_en) mem[wr_ptr] <= ch_data;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      overflow_count <= '0;
    else if (drop && overflow_count != 16'hFFFF)
      overflow_count <= overflow_count + 16'd1;
  end

  assign fill_level = fill_q;

  // A pop on the cycle the eop word is taken loads the next frame with no bubble.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      frame_q <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else if (pop) begin
      frame_q <= mem[rd_ptr];
      chan_q  <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && out_if.out_ready) begin
      if (chan_last) valid_q <= 1'b0;
      else           chan_q  <= chan_q + CW'(1);
    end
  end

  assign out_if.out_data  = frame_q[chan_q*W +: W];
  assign out_if.out_chan  = chan_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_sop   = valid_q && (chan_q == '0);
  assign out_if.out_eop   = valid_q && chan_last;

endmodule

// File: tb/tb_mic_array_capture.sv
// Directed bench for mic_array_capture: a 6-channel instance for the main modes and a
// 1-channel 24-bit instance for the parameter corner; both stream outputs are scoreboarded.
module tb_mic_array_capture;

  localparam int NCH  = 6;
  localparam int W    = 16;
  localparam int DEP  = 4;
  localparam int BL   = 3;
  localparam int CW   = 3;
  localparam int FW   = 3;
  localparam int W2   = 24;

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  chan;
    logic        sop;
    logic        eop;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  logic strobe_in;
  logic [NCH*W-1:0] ch_data;
  logic enable, oneshot, trigger;
  logic [FW-1:0] fill_level;
  logic [15:0] overflow_count;
  logic busy;

  logic [W2-1:0] ch_data2;
  logic enable2, oneshot2, trigger2;
  logic [FW-1:0] fill_level2;
  logic [15:0] overflow_count2;
  logic busy2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  word_t q1[$];
  word_t q2[$];

  always #5 clk = ~clk;

  mic_array_capture_if #(.W(W), .CW(CW)) s_if ();
  mic_array_capture_if #(.W(W2), .CW(1)) s2_if ();

  mic_array_capture #(.NCH(NCH), .W(W), .DEPTH(DEP), .BLOCK_LEN(BL)) dut (
    .clk_clk(clk), .reset_reset(rst), .sample_strobe_in(strobe_in), .ch_data(ch_data),
    .enable(enable), .oneshot(oneshot), .trigger(trigger), .out_if(s_if),
    .fill_level(fill_level), .overflow_count(overflow_count), .busy(busy)
  );

  mic_array_capture #(.NCH(1), .W(W2), .DEPTH(DEP), .BLOCK_LEN(1)) dut2 (
    .clk_clk(clk), .reset_reset(rst), .sample_strobe_in(strobe_in), .ch_data(ch_data2),
    .enable(enable2), .oneshot(oneshot2), .trigger(trigger2), .out_if(s2_if),
    .fill_level(fill_level2), .overflow_count(overflow_count2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic [23:0] d, input int c, input logic s, input logic e);
    word_t w;
    w.data = d;
    w.chan = 4'(c);
    w.sop  = s;
    w.eop  = e;
    return w;
  endfunction

  // Scoreboard pop at the falling edge: an accept happens at the following rising edge.
  always @(negedge clk) begin
    word_t got, exp;
    if (!rst && s_if.out_valid && s_if.out_ready) begin
      got = mk(24'(s_if.out_data), int'(s_if.out_chan), s_if.out_sop, s_if.out_eop);
      check("s1_word_expected", 64'(q1.size() != 0), 64'(1));
      if (q1.size() != 0) begin
        exp = q1.pop_front();
        check("s1_word", 64'(got), 64'(exp));
      end
    end
    if (!rst && s2_if.out_valid && s2_if.out_ready) begin
      got = mk(s2_if.out_data, int'(s2_if.out_chan), s2_if.out_sop, s2_if.out_eop);
      check("s2_word_expected", 64'(q2.size() != 0), 64'(1));
      if (q2.size() != 0) begin
        exp = q2.pop_front();
        check("s2_word", 64'(got), 64'(exp));
      end
    end
  end

  // One strobe pulse: 4 cycles high, 4 low. push1 says whether dut should store the frame.
  task automatic strobe(input bit push1, input logic [15:0] base);
    logic [31:0] r;
    for (int k = 0; k < NCH; k++) begin
      ch_data[k*W +: W] = base + 16'(k);
      if (push1) q1.push_back(mk(24'(base + 16'(k)), k, k == 0, k == NCH - 1));
    end
    r = $urandom;
    ch_data2 = r[23:0];
    q2.push_back(mk(r[23:0], 0, 1'b1, 1'b1));
    strobe_in = 1'b1;
    repeat (4) @(posedge clk);
    #1 strobe_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    check("drain_timeout", 64'(q1.size() + q2.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(posedge clk);
    #1 trigger = 1'b0;
  endtask

  initial begin
    int n;
    logic stable;
    rst = 1'b1; strobe_in = 1'b0; ch_data = '0; ch_data2 = '0;
    enable = 1'b0; oneshot = 1'b0; trigger = 1'b0;
    enable2 = 1'b1; oneshot2 = 1'b0; trigger2 = 1'b0;
    s_if.out_ready = 1'b0; s2_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(s_if.out_valid), 64'(0));
    check("rst_sop_eop_data", 64'({s_if.out_sop, s_if.out_eop, s_if.out_data}), 64'(0));
    check("rst_fill", 64'(fill_level), 64'(0));
    check("rst_ovf", 64'(overflow_count), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // continuous, single frame
    enable = 1'b1; oneshot = 1'b0; s_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    strobe(1'b1, 16'h1000);
    wait_empty(100);
    check("cont_fill", 64'(fill_level), 64'(0));

    // back-pressure
    s_if.out_ready = 1'b0;
    strobe(1'b1, 16'h2000);
    strobe(1'b1, 16'h2100);
    strobe(1'b1, 16'h2200);
    check("bp_fill", 64'(fill_level), 64'(2));
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(s_if.out_valid && s_if.out_sop && s_if.out_chan == '0 && s_if.out_data == 16'h2000))
        stable = 1'b0;
      @(posedge clk);
      #1;
    end
    check("bp_hold_stable", 64'(stable), 64'(1));
    s_if.out_ready = 1'b1;
    n = 0;
    while (q1.size() != 0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("bp_drain_cycles", 64'(n), 64'(18));
    wait_empty(100);

    // overflow
    s_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) strobe(i < 5, 16'h3000 + 16'(i * 256));
    check("ovf_fill", 64'(fill_level), 64'(4));
    check("ovf_count", 64'(overflow_count), 64'(5));
    s_if.out_ready = 1'b1;
    wait_empty(200);
    check("ovf_fill_drained", 64'(fill_level), 64'(0));
    check("ovf_count_held", 64'(overflow_count), 64'(5));

    // reset while a frame is mid-stream
    s_if.out_ready = 1'b0;
    strobe(1'b1, 16'h4000);
    strobe(1'b1, 16'h4100);
    s_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 s_if.out_ready = 1'b0;
    check("mid_chan", 64'({s_if.out_valid, s_if.out_chan}), 64'({1'b1, 3'd2}));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_valid", 64'(s_if.out_valid), 64'(0));
    check("mid_rst_fill", 64'(fill_level), 64'(0));
    check("mid_rst_ovf", 64'(overflow_count), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    q1.delete();
    rst = 1'b0;
    s_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_stale_output", 64'(s_if.out_valid), 64'(0));

    // one-shot block
    oneshot = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    strobe(1'b0, 16'h5000);
    strobe(1'b0, 16'h5100);
    check("armed_busy", 64'(busy), 64'(0));
    check("armed_fill", 64'(fill_level), 64'(0));
    pulse_trigger();
    check("trig_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 5; i++) begin
      strobe(i < 3, 16'h6000 + 16'(i * 256));
      if (i == 1) check("block_busy_mid", 64'(busy), 64'(1));
      if (i == 2) check("block_busy_end", 64'(busy), 64'(0));
    end
    wait_empty(200);
    check("block_fill", 64'(fill_level), 64'(0));
    pulse_trigger();
    strobe(1'b0, 16'h7000);
    check("done_ignores_trigger", 64'(busy), 64'(0));
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulse_trigger();
    check("rearm_busy", 64'(busy), 64'(1));
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abandon_busy", 64'(busy), 64'(0));

    wait_empty(200);
    check("s2_side_state", 64'({fill_level2, overflow_count2, busy2}), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mic_array_capture.md
Name: mic_array_capture

Overview:
- Parametrised successor to the fixed six-port 16-bit sound PIO capture.
- On each rising edge of the external data-clock strobe, snapshots all N microphone channels as one frame and writes it to an internal frame FIFO.
- Serialises buffered frames onto a valid/ready word stream toward the HPS-side DMA/bridge.
- Adds continuous and triggered one-shot block modes, occupancy reporting and overflow accounting.

Parameters:
- NCH, 6, number of microphone channels (1..16).
- W, 16, sample width in bits.
- DEPTH, 256, FIFO depth in frames (power of two, ≥2).
- BLOCK_LEN, 1024, frames captured per one-shot trigger (≥1).

Ports:
- clk_clk  in  1  system clock; all logic in this domain.
- reset_reset  in  1  synchronous active-high reset.
- sample_strobe_in  in  1  asynchronous data-clock strobe (clk_for_data); rising edge = new frame.
- ch_data  in  NCH*W  packed channel samples; channel k at bits [k*W+W-1 : k*W].
- enable  in  1  capture enable (level).
- oneshot  in  1  0 = continuous mode, 1 = triggered block mode.
- trigger  in  1  single-cycle start pulse for one-shot mode.
- out_data  out  W  current sample word.
- out_chan  out  max(1,clog2(NCH))  channel index of out_data.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream accept.
- out_sop  out  1  high with channel 0 word.
- out_eop  out  1  high with channel NCH-1 word.
- fill_level  out  clog2(DEPTH+1)  frames stored in FIFO; excludes the frame held in the serialiser.
- overflow_count  out  16  frames dropped due to full FIFO; saturates at 0xFFFF.
- busy  out  1  one-shot block in progress.

Behaviour:
- Reset: all outputs 0. FIFO is emptied, the serialiser is cleared, and the FSM goes to IDLE. Reset has priority over all inputs and aborts any frame in flight mid-stream; the partially sent frame is discarded.
- Strobe path:
  - sample_strobe_in passes through a 2-FF synchroniser, then a rising-edge detector.
  - The tick fires 3 clk_clk cycles after the input edge.
  - ch_data is sampled in the tick cycle.
  - Strobe edges closer together than 4 clk cycles are not guaranteed to produce distinct ticks.
- Write qualification: a tick produces a write only when the capture gate is open, as defined by the FSM below.
  - If gate open and FIFO full: frame dropped, overflow_count += 1 (saturating).
  - A dropped frame in one-shot mode still counts toward BLOCK_LEN.
- FSM:
  - IDLE: gate closed. If enable=1 and oneshot=0 -> CONT. If enable=1 and oneshot=1 -> ARMED.
  - CONT: gate open. enable=0 or oneshot=1 -> IDLE.
  - ARMED: gate closed. trigger=1 -> CAPTURE, with frame counter cleared. enable=0 -> IDLE.
  - CAPTURE: gate open; busy=1; each qualified tick increments the frame counter. After the BLOCK_LEN-th tick -> DONE. enable=0 -> IDLE, abandoning the block.
  - DONE: gate closed. trigger ignored. enable=0 -> IDLE, which then re-arms.
  - If a tick and the state exit occur in the same cycle, the tick is evaluated against the state before the exit.
- FIFO: stores NCH*W-bit frames. Simultaneous write and pop when full is allowed; the write succeeds and no overflow is counted. fill_level updates the cycle after a write or pop.
- Serialiser:
  - When idle and the FIFO is non-empty, it pops one frame. out_valid rises 1 cycle after the pop, presenting channel 0 with out_sop=1.
  - A word advances only on out_valid & out_ready. out_data, out_chan, out_sop and out_eop hold stable while out_valid=1 and out_ready=0.
  - After the channel NCH-1 word (out_eop=1) is accepted:
    - If the FIFO is non-empty, the next frame's channel 0 is presented in the following cycle, so there is no bubble.
    - Otherwise out_valid drops.
  - With NCH=1, out_sop and out_eop are both 1 on every word.
  - Channel order is always 0..NCH-1.
- Sustained throughput: 1 word per cycle when out_ready=1.

Test Plan:
- Reset and continuous capture: apply reset, then enable=1, oneshot=0, out_ready=1, ch_data channel k = 0x1000+k. Apply one strobe edge -> words 0x1000..0x1005 on out_chan 0..5, sop on the first word, eop on the last; fill_level returns to 0.
- Back-pressure: out_ready=0 throughout, 3 strobes -> fill_level=2 (one frame held in the serialiser); out_data stays at the channel 0 word, stable for 20 cycles. Release out_ready -> 18 words in order, no bubble.
- Overflow: DEPTH=4, out_ready=0, 10 strobes -> fill_level=4, overflow_count=5; after draining, 5 frames are emitted in strobe order.
- One-shot block: BLOCK_LEN=3, oneshot=1. 2 strobes before trigger -> no output. Pulse trigger, then 5 strobes -> exactly 3 frames; busy is high from trigger until after the 3rd tick, and the state is DONE.
- Reset mid-operation: assert reset while out_chan=2 with out_valid=1 -> next cycle out_valid=0, fill_level=0, overflow_count=0, state IDLE.
- Parameter sweep: NCH=1, W=24 -> every word has sop=eop=1 and out_chan=0; 24-bit data is passed bit-exact.
